uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Consumes the CPU's UART store strobe (store to 0x1000_0000) and puts each byte on a serial line.
//  Sits directly downstream of the CPU top: wr_en <- debug_uart_en, wr_data <- debug_uart_data.
//  Buffers bytes in a FIFO so single-cycle stores never stall the core.
//  Serialises each byte as 8N1, LSB first, at a fixed baud divisor.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    16   FIFO entries; power of two, >= 2
//  FIFO_AW       $clog2(FIFO_DEPTH)  derived local; not overridden
// PORTS
//  clk         in   1          system clock; all state on posedge
//  rst_n       in   1          asynchronous, active-low reset
//  wr_en       in   1          push strobe, one byte per cycle
//  wr_data     in   32         only [7:0] is used; [31:8] ignored
//  tx          out  1          serial line, registered; idle high
//  tx_busy     out  1          1 while a frame is on the line
//  fifo_full   out  1          FIFO holds FIFO_DEPTH bytes
//  fifo_empty  out  1          FIFO holds 0 bytes
//  fifo_level  out  FIFO_AW+1  current occupancy, 0..FIFO_DEPTH
//  drop_cnt    out  16         count of pushes dropped on full; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync release):
//   tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_level=0, drop_cnt=0, FSM=IDLE.
//   Mid-frame reset aborts the frame: tx returns high immediately and FIFO contents are discarded.
//  Push:
//   - wr_en && !fifo_full stores wr_data[7:0] at the tail.
//   - wr_en && fifo_full drops the byte and increments drop_cnt.
//   - Full is evaluated on the registered state. A pop in the same cycle does not admit a push when full.
//   - Simultaneous push+pop when not full leaves fifo_level unchanged.
//  Pointers: FIFO_AW-bit head/tail wrap modulo FIFO_DEPTH; fifo_level tracks occupancy separately.
//  FSM states: IDLE, START, DATA, [PARITY], STOP. Each non-IDLE state lasts exactly CLKS_PER_BIT cycles.
//   - Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
//   - IDLE: tx=1, tx_busy=0. If !fifo_empty: pop head into an 8-bit shift reg -> START.
//   - START: tx=0. -> DATA with bit_idx=0.
//   - DATA: tx=shift[0]. Shift right at the end of each bit. After bit_idx==7 -> PARITY if enabled, else STOP.
//   - STOP: tx=1. At the end, pop and go straight to START if !fifo_empty (no idle gap), else IDLE.
//  tx_busy=1 in every state except IDLE.
//  Latency: wr_en in cycle 0 into an empty FIFO (FSM IDLE) -> fifo_empty falls in cycle 1 -> pop in cycle 1 -> tx falls in cycle 2.
//  Frame length: 10*CLKS_PER_BIT cycles (11* with parity).
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - Adds the PARITY state after DATA.
//   - tx = even parity (^byte) for CLKS_PER_BIT cycles; frame becomes 8E1.
//  Undefined: no PARITY state; frame is 8N1; no parity logic is synthesised.
// STRUCTURE
//  Shared package uart_pkg:
//   - FSM state encoding localparams (IDLE/START/DATA/PARITY/STOP, 3 bits).
//   - UART_TX_ADDR = 32'h1000_0000.
//   - DEFAULT_CLKS_PER_BIT.
//  Sub-module uart_tx_fifo: synchronous FIFO (push/pop/full/empty/level, async active-low reset).
//  uart_tx contains the FIFO instance, baud counter, shift register, FSM and drop counter.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=16)
//  1. Assert rst_n=0 -> tx=1, tx_busy=0, fifo_empty=1, fifo_level=0, drop_cnt=0.
//  2. Single push 0x55 in cycle 0 -> tx=0 during cycles 2-5, then bits 1,0,1,0,1,0,1,0 at 4 cycles each,
//     then stop=1 for cycles 38-41 -> tx_busy=0 in cycle 42.
//  3. 17 pushes on consecutive cycles while FSM is in IDLE -> first byte popped in cycle 1;
//     fifo_full=1 after the 17th push; drop_cnt stays 0; all 17 frames follow back-to-back, no idle gap.
//     Repeat with pushes held off until the first frame starts, then 17 pushes -> 16 accepted, fifo_full=1, drop_cnt=1.
//  4. Push wr_data=32'hDEAD_BE41 -> line carries 0x41 only.
//  5. Deassert rst_n during the DATA phase -> tx=1 in the same cycle, fifo_level=0;
//     after release with no pushes -> tx stays 1.
//  6. UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frame 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, MMIO address of the
// UART data register and the default baud divisor (100 MHz / 115200).
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic [31:0] UART_TX_ADDR         = 32'h1000_0000;
  localparam int          DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO that absorbs single-cycle CPU stores ahead of the
// serialiser. Pointers wrap modulo DEPTH; occupancy is tracked in its own counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[head_q];

  // Full is judged on registered occupancy, so a same-cycle pop never frees room for a push.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter fed by the CPU's UART store strobe; 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = 16,
  localparam int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic             tx,
  output logic             tx_busy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [FIFO_AW:0] fifo_level,
  output logic [15:0]      drop_cnt
);

  localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [15:0]      drop_q, drop_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             bit_end;
  logic             load_next;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^wr_data[31:8];

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_en),
    .push_data(wr_data[7:0]),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign bit_end  = (cnt_q == CNT_MAX);
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign drop_cnt = drop_q;

  // Outputs are computed one cycle ahead so tx/tx_busy come straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    drop_d    = drop_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: load_next = !fifo_empty;
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            load_next = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Leaving STOP with data waiting chains straight into the next start bit.
    if (load_next) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      state_d  = START;
      cnt_d    = '0;
      tx_d     = 1'b0;
      busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end

    if (wr_en && fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      drop_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Define UART_TX_PARITY_EN here as well to check 8E1 frames.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10 * CPB;
  localparam bit PAR   = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic        tx, tx_busy, fifo_full, fifo_empty;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_level(fifo_level),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus the cycle at which the line becomes free.
  // A frame popped at edge k occupies cycles k+1 .. k+FRAME on the line.
  logic [7:0] mq[$];
  int         cyc      = 0;
  int         next_pop = 0;
  int         fs       = 0;
  int         mdrop    = 0;
  logic [7:0] fbyte    = '0;
  bit         fvalid   = 1'b0;
  bit         m_full;
  logic       line_buf [0:2047];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      fvalid   = 1'b0;
      mdrop    = 0;
      next_pop = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (cyc >= next_pop && mq.size() > 0) begin
        fbyte    = mq.pop_front();
        fs       = cyc + 1;
        fvalid   = 1'b1;
        next_pop = cyc + FRAME;
      end
      if (wr_en) begin
        if (m_full) begin
          if (mdrop < 65535) mdrop++;
        end else begin
          mq.push_back(wr_data[7:0]);
        end
      end
      cyc++;
    end
  end

  // Expected {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} for the current cycle.
  function automatic logic [24:0] model_vec();
    logic t = 1'b1;
    logic b = 1'b0;
    int   off;
    if (fvalid && cyc >= fs && cyc < fs + FRAME) begin
      b   = 1'b1;
      off = (cyc - fs) / CPB;
      if (off == 0)             t = 1'b0;
      else if (off <= 8)        t = fbyte[off-1];
      else if (PAR && off == 9) t = ^fbyte;
      else                      t = 1'b1;
    end
    return {t, b, mq.size() == DEPTH, mq.size() == 0, 5'(mq.size()), 16'(mdrop)};
  endfunction

  // Reads a byte off the captured line, given the cycle index of its start bit.
  function automatic logic [7:0] decode(input int s);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = line_buf[s + CPB * (b + 1) + CPB / 2];
    return v;
  endfunction

  task automatic test_reset();
    logic [24:0] exp;
    @(negedge clk);
    total++; if (tx !== 1'b1)         begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
    total++; if (tx_busy !== 1'b0)    begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", tx_busy); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", fifo_empty); end
    total++; if (fifo_full !== 1'b0)  begin bad++; $display("[TB] FAIL reset_full got=%b want=0", fifo_full); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", fifo_level); end
    total++; if (drop_cnt !== 16'd0)  begin bad++; $display("[TB] FAIL reset_drop got=%0d want=0", drop_cnt); end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL reset_idle cyc=%0d got=%h want=%h", cyc, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
    end
  endtask

  task automatic test_single_byte(input logic [31:0] data, input logic [7:0] want, input string name);
    logic [24:0] exp;
    int first_low = -1;
    int busy_n    = 0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL %s_line i=%0d got=%h want=%h", name, i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      line_buf[i] = tx;
      if (tx === 1'b0 && first_low < 0) first_low = i;
      if (tx_busy === 1'b1) busy_n++;
      wr_en   = (i == 0);
      wr_data = data;
    end
    wr_en = 1'b0;
    total++; if (first_low !== 2) begin bad++; $display("[TB] FAIL %s_latency got=%0d want=2", name, first_low); end
    total++; if (busy_n !== FRAME) begin bad++; $display("[TB] FAIL %s_busy_len got=%0d want=%0d", name, busy_n, FRAME); end
    total++; if (decode(2) !== want) begin bad++; $display("[TB] FAIL %s_byte got=%h want=%h", name, decode(2), want); end
    total++; if (line_buf[2 + FRAME - CPB / 2] !== 1'b1) begin bad++; $display("[TB] FAIL %s_stop got=%b want=1", name, line_buf[2 + FRAME - CPB / 2]); end
  endtask

  task automatic test_burst17();
    logic [24:0] exp;
    int first_busy = -1;
    int last_busy  = -1;
    int busy_n     = 0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 17 * FRAME + 12; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL burst_line i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      if (i == 17) begin
        total++; if (fifo_full !== 1'b1) begin bad++; $display("[TB] FAIL burst_full got=%b want=1", fifo_full); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL burst_drop got=%0d want=0", drop_cnt); end
      end
      if (tx_busy === 1'b1) begin
        busy_n++;
        if (first_busy < 0) first_busy = i;
        last_busy = i;
      end
      wr_en   = (i < 17);
      wr_data = $urandom;
    end
    wr_en = 1'b0;
    total++; if (first_busy !== 2) begin bad++; $display("[TB] FAIL burst_first_pop got=%0d want=2", first_busy); end
    total++; if (busy_n !== 17 * FRAME) begin bad++; $display("[TB] FAIL burst_busy_len got=%0d want=%0d", busy_n, 17 * FRAME); end
    total++; if (last_busy - first_busy + 1 !== busy_n) begin bad++; $display("[TB] FAIL burst_gap got=%0d want=%0d", last_busy - first_busy + 1, busy_n); end
  endtask

  task automatic test_overflow_drop();
    logic [24:0] exp;
    int start = -1;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 17 * FRAME + 12; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL ovf_line i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      if (tx === 1'b0 && start < 0) start = i;
      if (start >= 0 && i == start + 17) begin
        total++; if (fifo_full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_full got=%b want=1", fifo_full); end
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL ovf_drop got=%0d want=1", drop_cnt); end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=16", fifo_level); end
      end
      wr_en   = (i == 0) || (start >= 0 && i >= start && i < start + 17);
      wr_data = $urandom;
    end
    wr_en = 1'b0;
    total++; if (start !== 2) begin bad++; $display("[TB] FAIL ovf_start got=%0d want=2", start); end
  endtask

  task automatic test_mid_frame_reset();
    logic [24:0] exp;
    int lows = 0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 + 3 * CPB; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL midrst_line i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      wr_en   = (i < 3);
      wr_data = 32'h0000_0000 | $urandom_range(0, 255);
    end
    wr_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1)         begin bad++; $display("[TB] FAIL midrst_tx got=%b want=1", tx); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL midrst_level got=%0d want=0", fifo_level); end
    total++; if (tx_busy !== 1'b0)    begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", tx_busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL midrst_after i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("[TB] FAIL midrst_quiet got=%0d want=0", lows); end
  endtask

  task automatic test_parity_pair();
    logic [24:0] exp;
    int busy_n = 0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL pair_line i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      line_buf[i] = tx;
      if (tx_busy === 1'b1) busy_n++;
      wr_en   = (i < 2);
      wr_data = (i == 0) ? 32'h07 : 32'h03;
    end
    wr_en = 1'b0;
    total++; if (busy_n !== 2 * FRAME) begin bad++; $display("[TB] FAIL pair_busy_len got=%0d want=%0d", busy_n, 2 * FRAME); end
    total++; if (decode(2) !== 8'h07) begin bad++; $display("[TB] FAIL pair_byte0 got=%h want=07", decode(2)); end
    total++; if (decode(2 + FRAME) !== 8'h03) begin bad++; $display("[TB] FAIL pair_byte1 got=%h want=03", decode(2 + FRAME)); end
`ifdef UART_TX_PARITY_EN
    total++; if (line_buf[2 + 9 * CPB + 1] !== 1'b1) begin bad++; $display("[TB] FAIL parity_07 got=%b want=1", line_buf[2 + 9 * CPB + 1]); end
    total++; if (line_buf[2 + FRAME + 9 * CPB + 1] !== 1'b0) begin bad++; $display("[TB] FAIL parity_03 got=%b want=0", line_buf[2 + FRAME + 9 * CPB + 1]); end
`endif
  endtask

  task automatic test_random_traffic();
    logic [24:0] exp;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      exp = model_vec(); total++;
      if ({tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt} !== exp) begin
        bad++; $display("[TB] FAIL random_line i=%0d got=%h want=%h", i, {tx, tx_busy, fifo_full, fifo_empty, fifo_level, drop_cnt}, exp);
      end
      if (i < 200)      wr_en = ($urandom_range(0, 9) == 0);
      else if (i < 260) wr_en = 1'b1;
      else if (i < 320) wr_en = ($urandom_range(0, 3) == 0);
      else              wr_en = 1'b0;
      wr_data = $urandom;
    end
    wr_en = 1'b0;
    total++; if (drop_cnt === 16'd0) begin bad++; $display("[TB] FAIL random_drops got=%0d want=nonzero", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte(32'h0000_0055, 8'h55, "single55");
    test_burst17();
    test_overflow_drop();
    test_single_byte(32'hDEAD_BE41, 8'h41, "upper_bits");
    test_mid_frame_reset();
    test_parity_pair();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
